// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle for pipe_stage_reg.
// Groups the upstream side (in_*), the downstream side (out_*), flush and the
// stall counter. Clock and reset stay plain ports on the stage itself.
//   master : the environment around the stage (drives in_*, flush, out_ready)
//   slave  : the stage (drives in_ready, out_*, stall_cnt)
// CTRL_W / DATA_W / CNT_W must match the parameters of the attached stage.
interface pipe_stage_reg_if #(
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-NOP and a
// saturating stall-cycle counter.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : two-entry stage (main + skid); in_ready comes from flops only.
//   undefined : single-entry stage; in_ready = (!out_valid || out_ready) && !flush.
//
// Ports:
//   clk_50MHz : clock, rising edge
//   rst       : asynchronous active-low reset
//   pipe_io   : pipe_stage_reg_if.slave
//     in_valid/in_ready/in_ctrl/in_data    upstream entry
//     flush                                kill held and incoming entries
//     out_valid/out_ready/out_ctrl/out_data head entry (out_ctrl = NOP_CTRL when empty)
//     stall_cnt                            saturating count of out_valid && !out_ready
//
// Control fields are forced to NOP_CTRL whenever no valid head exists; data
// fields only change when a new entry is loaded or on reset.
module pipe_stage_reg #(
  parameter int unsigned       CTRL_W   = 32,
  parameter int unsigned       DATA_W   = 128,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input logic             clk_50MHz,
  input logic             rst,
  pipe_stage_reg_if.slave pipe_io
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
`endif

  logic in_ready;
  logic in_fire;
  logic out_fire;

`ifdef PIPE_STAGE_SKID_EN
  // Registered backpressure: skid absorbs the one entry that arrives while
  // upstream has not yet seen in_ready drop.
  assign in_ready = !skid_valid_q && !pipe_io.flush;
`else
  assign in_ready = (!main_valid_q || pipe_io.out_ready) && !pipe_io.flush;
`endif

  assign in_fire  = pipe_io.in_valid && in_ready;
  assign out_fire = main_valid_q && pipe_io.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
`endif

    if (pipe_io.flush) begin
      // Only valid bits are killed; data registers keep their contents.
      main_valid_d = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (out_fire) begin
`ifdef PIPE_STAGE_SKID_EN
      // in_ready is low while skid is full, so skid cannot refill here.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else
`endif
      begin
        // Pass-through when input fires in the same cycle, else drain.
        main_valid_d = in_fire;
        if (in_fire) begin
          main_ctrl_d = pipe_io.in_ctrl;
          main_data_d = pipe_io.in_data;
        end
      end
    end else if (!main_valid_q) begin
      main_valid_d = in_fire;
      if (in_fire) begin
        main_ctrl_d = pipe_io.in_ctrl;
        main_data_d = pipe_io.in_data;
      end
    end
`ifdef PIPE_STAGE_SKID_EN
    else if (in_fire) begin
      // Head is stalled: second entry parks in skid.
      skid_valid_d = 1'b1;
      skid_ctrl_d  = pipe_io.in_ctrl;
      skid_data_d  = pipe_io.in_data;
    end
`endif
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !pipe_io.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= NOP_CTRL;
      main_data_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= NOP_CTRL;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end
`endif

  assign pipe_io.in_ready  = in_ready;
  assign pipe_io.out_valid = main_valid_q;
  assign pipe_io.out_ctrl  = main_valid_q ? main_ctrl_q : NOP_CTRL;
  assign pipe_io.out_data  = main_data_q;
  assign pipe_io.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. Works for both builds; expectations that
// differ between builds are selected with PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int unsigned CtrlW = 32;
  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = 4;
  localparam logic [CtrlW-1:0] NopCtrl = 32'hDEAD0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipe_stage_reg_if #(.CTRL_W(CtrlW), .DATA_W(DataW), .CNT_W(CntW)) bus ();

  pipe_stage_reg #(
    .CTRL_W   (CtrlW),
    .DATA_W   (DataW),
    .NOP_CTRL (NopCtrl),
    .CNT_W    (CntW)
  ) u_dut (
    .clk_50MHz (clk),
    .rst       (rst),
    .pipe_io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] c, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  int exp_stall;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 32'h0, 16'h0);

    // ---------------- reset ----------------
    #3;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("rst_out_ctrl", bus.out_ctrl, NopCtrl);
    check_val("rst_out_data", 32'(bus.out_data), 32'h0);
    check_val("rst_stall", 32'(bus.stall_cnt), 32'h0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_val("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("post_rst_out_ctrl", bus.out_ctrl, NopCtrl);
    check_val("post_rst_stall", 32'(bus.stall_cnt), 32'h0);

    // ---------------- streaming ----------------
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_in(1'b1, 32'(i), 16'(16'h0100 + i));
      tick();
      check_val($sformatf("stream_valid_%0d", i), 32'(bus.out_valid), 32'h1);
      check_val($sformatf("stream_ctrl_%0d", i), bus.out_ctrl, 32'(i));
      check_val($sformatf("stream_data_%0d", i), 32'(bus.out_data), 32'(16'h0100 + i));
    end
    drive_in(1'b0, 32'h0, 16'h0);
    tick();
    check_val("stream_drain_valid", 32'(bus.out_valid), 32'h0);
    check_val("stream_drain_ctrl", bus.out_ctrl, NopCtrl);
    check_val("stream_stall", 32'(bus.stall_cnt), 32'h0);

    // ---------------- backpressure ----------------
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h0A, 16'h00A0);
    tick();                                   // A -> main
    check_val("bp_a_ctrl", bus.out_ctrl, 32'h0A);
    drive_in(1'b1, 32'h0B, 16'h00B0);
`ifdef PIPE_STAGE_SKID_EN
    #1;
    check_val("bp_b_in_ready", 32'(bus.in_ready), 32'h1);
    tick();                                   // B -> skid, stall 1
    drive_in(1'b1, 32'h0C, 16'h00C0);
    #1;
    check_val("bp_c_in_ready", 32'(bus.in_ready), 32'h0);
    tick();                                   // stall 2
    tick();                                   // stall 3
    check_val("bp_stall", 32'(bus.stall_cnt), 32'h3);
    check_val("bp_hold_ctrl", bus.out_ctrl, 32'h0A);
    bus.out_ready = 1'b1;
    #1;
    check_val("bp_reg_in_ready", 32'(bus.in_ready), 32'h0);
    tick();                                   // A out, B -> main
    check_val("bp_out_b", bus.out_ctrl, 32'h0B);
    check_val("bp_b_data", 32'(bus.out_data), 32'h00B0);
    tick();                                   // B out, C -> main
    check_val("bp_out_c", bus.out_ctrl, 32'h0C);
    check_val("bp_c_data", 32'(bus.out_data), 32'h00C0);
`else
    #1;
    check_val("bp_b_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    tick();                                   // stall 3
    check_val("bp_stall", 32'(bus.stall_cnt), 32'h3);
    check_val("bp_hold_ctrl", bus.out_ctrl, 32'h0A);
    bus.out_ready = 1'b1;
    #1;
    check_val("bp_comb_in_ready", 32'(bus.in_ready), 32'h1);
    tick();                                   // A out, B in together
    check_val("bp_pass_valid", 32'(bus.out_valid), 32'h1);
    check_val("bp_out_b", bus.out_ctrl, 32'h0B);
    drive_in(1'b1, 32'h0C, 16'h00C0);
    tick();
    check_val("bp_out_c", bus.out_ctrl, 32'h0C);
    check_val("bp_c_data", 32'(bus.out_data), 32'h00C0);
`endif
    drive_in(1'b0, 32'h0, 16'h0);
    tick();
    check_val("bp_empty", 32'(bus.out_valid), 32'h0);
    check_val("bp_stall_final", 32'(bus.stall_cnt), 32'h3);

    // ---------------- flush collision ----------------
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h11, 16'h0111);
    tick();                                   // A2 -> main
`ifdef PIPE_STAGE_SKID_EN
    drive_in(1'b1, 32'h12, 16'h0112);
    tick();                                   // B2 -> skid, stall 4
    exp_stall = 5;
`else
    exp_stall = 4;
`endif
    bus.flush = 1'b1;
    drive_in(1'b1, 32'h13, 16'h0113);
    #1;
    check_val("flush_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_val("flush_valid", 32'(bus.out_valid), 32'h0);
    check_val("flush_ctrl", bus.out_ctrl, NopCtrl);
    check_val("flush_data_held", 32'(bus.out_data), 32'h0111);
    check_val("flush_stall", 32'(bus.stall_cnt), 32'(exp_stall));
    bus.flush = 1'b0;
    drive_in(1'b0, 32'h0, 16'h0);
    bus.out_ready = 1'b1;
    tick();
    check_val("flush_no_resurrect", 32'(bus.out_valid), 32'h0);

    // ---------------- saturation ----------------
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h21, 16'h0221);
    tick();                                   // D -> main, no count yet
    drive_in(1'b0, 32'h0, 16'h0);
    tick();
    check_val("sat_first_inc", 32'(bus.stall_cnt), 32'(exp_stall + 1));
    for (int i = 0; i < 19; i++) tick();
    check_val("sat_value", 32'(bus.stall_cnt), 32'hF);
    bus.out_ready = 1'b1;
    tick();
    check_val("sat_hold", 32'(bus.stall_cnt), 32'hF);
    check_val("sat_drained", 32'(bus.out_valid), 32'h0);

    // ---------------- reset mid-transfer ----------------
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h31, 16'h0331);
    tick();
    check_val("mid_loaded", bus.out_ctrl, 32'h31);
    rst = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check_val("mid_rst_ctrl", bus.out_ctrl, NopCtrl);
    check_val("mid_rst_data", 32'(bus.out_data), 32'h0);
    check_val("mid_rst_stall", 32'(bus.stall_cnt), 32'h0);
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive_in(1'b1, 32'h77, 16'h0777);
    tick();
    check_val("post_mid_accept", bus.out_ctrl, 32'h77);
    drive_in(1'b0, 32'h0, 16'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end

endmodule
